// File: rtl/color_order_dispatcher_if.sv
// ---------------------------------------------------------------------------
// color_order_dispatcher_if : order intake / box-stage bundle for the
//                             colour order dispatcher
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface color_order_dispatcher_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          order_valid;
  logic [3:0]    order_id;
  logic          order_ready;
  logic [3:0]    color_id;
  logic          dispense_start;
  logic          busy;
  logic [CW-1:0] queue_count;
  logic          order_err;

  modport master (
    output order_valid, order_id,
    input  order_ready, color_id, dispense_start, busy, queue_count, order_err
  );

  modport slave (
    input  order_valid, order_id,
    output order_ready, color_id, dispense_start, busy, queue_count, order_err
  );
endinterface

`default_nettype wire

// File: rtl/color_order_dispatcher.sv
// ---------------------------------------------------------------------------
// color_order_dispatcher : buffers colour orders in a FIFO and presents them
//                          one at a time for a dispense window plus gap
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module color_order_dispatcher #(
  parameter int          DEPTH           = 4,
  parameter int unsigned DISPENSE_CYCLES = 100_000_000,
  parameter int unsigned GAP_CYCLES      = 10_000_000,
  parameter int          ID_MAX          = 11
) (
  input  wire                      clk,
  input  wire                      rst,
  color_order_dispatcher_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0]    ID_MAX_L  = 4'(ID_MAX);
  localparam logic [CW-1:0] DEPTH_L   = CW'(DEPTH);
  localparam logic [31:0]   DISP_LAST = 32'(DISPENSE_CYCLES - 1);
  localparam logic [31:0]   GAP_LAST  = 32'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DISP = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   timer_q, timer_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    color_q, color_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [3:0]    mem_q [DEPTH];

  logic          ready;
  logic          push;
  logic          pop;

  // Readiness comes from the registered count only, so a same-edge pop
  // never opens a slot for a push into a full FIFO.
  assign ready = (count_q < DEPTH_L);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    color_d  = color_q;
    start_d  = 1'b0;
    busy_d   = busy_q;
    pop      = 1'b0;

    push  = bus.order_valid && ready && (bus.order_id <= ID_MAX_L);
    err_d = bus.order_valid && !push;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    case (state_q)
      S_IDLE: begin
        color_d = 4'd0;
        busy_d  = 1'b0;
        if (count_q != '0) begin
          pop      = 1'b1;
          rd_ptr_d = rd_ptr_q + PW'(1);
          color_d  = mem_q[rd_ptr_q];
          start_d  = 1'b1;
          busy_d   = 1'b1;
          timer_d  = 32'd0;
          state_d  = S_DISP;
        end
      end
      S_DISP: begin
        if (timer_q == DISP_LAST) begin
          state_d = S_GAP;
          color_d = 4'd0;
          timer_d = 32'd0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_GAP: begin
        color_d = 4'd0;
        busy_d  = 1'b1;
        if (timer_q == GAP_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          timer_d = 32'd0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        color_d = 4'd0;
        busy_d  = 1'b0;
        timer_d = 32'd0;
      end
    endcase

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= 32'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      color_q  <= 4'd0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      color_q  <= color_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.order_id;
  end

  assign bus.order_ready    = ready;
  assign bus.color_id       = color_q;
  assign bus.dispense_start = start_q;
  assign bus.busy           = busy_q;
  assign bus.queue_count    = count_q;
  assign bus.order_err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_color_order_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_color_order_dispatcher : directed self-checking bench for the dispatcher
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_color_order_dispatcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [3:0] disp_q[$];
  int         err_pulses  = 0;
  int         start_cnt   = 0;
  int         ready_viol  = 0;

  always #5 clk = ~clk;

  color_order_dispatcher_if #(.DEPTH(4)) bus ();

  color_order_dispatcher #(
    .DEPTH(4),
    .DISPENSE_CYCLES(10),
    .GAP_CYCLES(4),
    .ID_MAX(11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dispense_start) begin
        disp_q.push_back(bus.color_id);
        start_cnt++;
      end
      if (bus.order_err) err_pulses++;
      if (bus.order_ready !== (bus.queue_count < 3'd4)) ready_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] id);
    bus.order_valid = 1'b1;
    bus.order_id    = id;
    tick();
    bus.order_valid = 1'b0;
    bus.order_id    = 4'd0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    while (!(bus.busy == 1'b0 && bus.queue_count == 3'd0) && n < bound) begin
      tick();
      n++;
    end
    check(tag, 32'(n < bound), 32'd1);
  endtask

  task automatic check_seq(input string tag, input logic [3:0] exp[$]);
    check({tag, "_len"}, 32'(disp_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < disp_q.size(); i++)
      check(tag, 32'(disp_q[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [3:0] seq[$];
    logic [3:0] wrap_ids[$];
    int         e0;
    int         s0;
    int         n;

    bus.order_valid = 1'b0;
    bus.order_id    = 4'd0;

    // Reset state
    repeat (3) tick();
    check("rst_color", 32'(bus.color_id), 32'd0);
    check("rst_start", 32'(bus.dispense_start), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_count", 32'(bus.queue_count), 32'd0);
    check("rst_err", 32'(bus.order_err), 32'd0);
    check("rst_ready", 32'(bus.order_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Single order 7: window of 10 then gap of 4
    send(4'd7);
    check("s1_count_q", 32'(bus.queue_count), 32'd1);
    check("s1_color_pre", 32'(bus.color_id), 32'd0);
    tick();
    check("s1_color", 32'(bus.color_id), 32'd7);
    check("s1_start", 32'(bus.dispense_start), 32'd1);
    check("s1_busy", 32'(bus.busy), 32'd1);
    check("s1_count_pop", 32'(bus.queue_count), 32'd0);
    tick();
    check("s1_start_low", 32'(bus.dispense_start), 32'd0);
    repeat (8) tick();
    check("s1_color_last", 32'(bus.color_id), 32'd7);
    tick();
    check("s1_gap_color", 32'(bus.color_id), 32'd0);
    check("s1_gap_busy", 32'(bus.busy), 32'd1);
    repeat (3) tick();
    check("s1_gap_end_busy", 32'(bus.busy), 32'd1);
    tick();
    check("s1_idle_busy", 32'(bus.busy), 32'd0);
    check("s1_idle_count", 32'(bus.queue_count), 32'd0);
    seq = '{4'd7};
    check_seq("s1_seq", seq);

    // Orders 1..5 back to back
    disp_q.delete();
    send(4'd1); check("q5_c1", 32'(bus.queue_count), 32'd1);
    send(4'd2); check("q5_c2", 32'(bus.queue_count), 32'd1);
    check("q5_first_color", 32'(bus.color_id), 32'd1);
    send(4'd3); check("q5_c3", 32'(bus.queue_count), 32'd2);
    send(4'd4); check("q5_c4", 32'(bus.queue_count), 32'd3);
    check("q5_ready_hi", 32'(bus.order_ready), 32'd1);
    send(4'd5); check("q5_c5", 32'(bus.queue_count), 32'd4);
    check("q5_ready_lo", 32'(bus.order_ready), 32'd0);
    wait_idle(200, "q5_idle_timeout");
    seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    check_seq("q5_seq", seq);
    check("q5_no_err", 32'(err_pulses), 32'd0);

    // Orders 1..6: id 6 hits a full FIFO
    disp_q.delete();
    e0 = err_pulses;
    for (int i = 1; i <= 5; i++) send(4'(i));
    send(4'd6);
    check("full_err", 32'(bus.order_err), 32'd1);
    check("full_count", 32'(bus.queue_count), 32'd4);
    tick();
    check("full_err_clr", 32'(bus.order_err), 32'd0);
    wait_idle(200, "full_idle_timeout");
    check_seq("full_seq", seq);
    check("full_err_cnt", 32'(err_pulses - e0), 32'd1);

    // Illegal codes 12 and 15
    disp_q.delete();
    e0 = err_pulses;
    send(4'd12);
    check("bad12_err", 32'(bus.order_err), 32'd1);
    check("bad12_count", 32'(bus.queue_count), 32'd0);
    send(4'd15);
    check("bad15_err", 32'(bus.order_err), 32'd1);
    check("bad15_count", 32'(bus.queue_count), 32'd0);
    tick();
    check("bad_err_clr", 32'(bus.order_err), 32'd0);
    check("bad_color", 32'(bus.color_id), 32'd0);
    check("bad_busy", 32'(bus.busy), 32'd0);
    check("bad_err_cnt", 32'(err_pulses - e0), 32'd2);
    check("bad_no_disp", 32'(disp_q.size()), 32'd0);

    // Push coincident with pop on the return to IDLE
    send(4'd9);
    tick();
    send(4'd3);
    check("cp_count_q", 32'(bus.queue_count), 32'd1);
    n = 0;
    while (bus.busy == 1'b1 && n < 100) begin tick(); n++; end
    check("cp_busy_fall_timeout", 32'(n < 100), 32'd1);
    check("cp_idle_count", 32'(bus.queue_count), 32'd1);
    send(4'd5);
    check("cp_count_same", 32'(bus.queue_count), 32'd1);
    check("cp_color", 32'(bus.color_id), 32'd3);
    check("cp_start", 32'(bus.dispense_start), 32'd1);
    wait_idle(200, "cp_idle_timeout");
    seq = '{4'd9, 4'd3, 4'd5};
    check_seq("cp_seq", seq);

    // Asynchronous reset mid-dispense with three queued
    disp_q.delete();
    send(4'd1); send(4'd2); send(4'd3); send(4'd4);
    check("ar_count_pre", 32'(bus.queue_count), 32'd3);
    tick(); tick();
    check("ar_color_pre", 32'(bus.color_id), 32'd1);
    rst = 1'b1;
    #1;
    check("ar_color", 32'(bus.color_id), 32'd0);
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_count", 32'(bus.queue_count), 32'd0);
    tick(); tick();
    rst = 1'b0;
    s0 = start_cnt;
    repeat (20) tick();
    check("ar_no_start", 32'(start_cnt - s0), 32'd0);
    check("ar_color_idle", 32'(bus.color_id), 32'd0);

    // Ten spread orders wrap the pointers
    disp_q.delete();
    e0 = err_pulses;
    wrap_ids = '{4'd3, 4'd0, 4'd11, 4'd6, 4'd2, 4'd9, 4'd1, 4'd10, 4'd4, 4'd8};
    for (int i = 0; i < 10; i++) begin
      send(wrap_ids[i]);
      repeat (3 * i) tick();
    end
    wait_idle(400, "wrap_idle_timeout");
    check_seq("wrap_seq", wrap_ids);
    check("wrap_no_err", 32'(err_pulses - e0), 32'd0);
    check("ready_tracks_count", 32'(ready_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
